bp_lite_to_stream: RTL and testbench

- Serializes one BP Lite memory message (header plus full-width data) into a BP Stream: a header-qualified sequence of narrow data beats.
- Sits directly upstream of the stream-to-lite converter, or of any stream consumer such as a wormhole adapter.
- Performs the lite-to-stream direction of the same mem interface, so that converter (or a stream link into it) consumes its output unchanged.
- Each beat carries a copy of the header with an advancing address.

---
 rtl/bp_lite_to_stream.sv | 130 +++++++++++++
 tb/tb_bp_lite_to_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lite_to_stream.sv
// rtl/bp_lite_to_stream.sv - serializes one lite mem message into header-qualified stream beats
module bp_lite_to_stream #(
    parameter int paddr_width_p    = 40,
    parameter int payload_width_p  = 24,
    parameter int in_data_width_p  = 512,
    parameter int out_data_width_p = 64,
    parameter bit master_p         = 1'b0,
    localparam int mem_header_width_lp = 4 + paddr_width_p + 3 + payload_width_p
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [mem_header_width_lp+in_data_width_p-1:0] mem_i,
    input  logic                                       mem_v_i,
    output logic                                       mem_ready_o,
    output logic [mem_header_width_lp-1:0]             mem_header_o,
    output logic [out_data_width_p-1:0]                mem_data_o,
    output logic                                       mem_v_o,
    input  logic                                       mem_ready_and_i,
    output logic                                       mem_lock_o
);

    localparam int max_beats_lp   = in_data_width_p / out_data_width_p;
    localparam int cnt_width_lp   = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
    localparam int bytes_lp       = out_data_width_p / 8;
    localparam int lg_bytes_lp    = $clog2(bytes_lp);
    localparam int addr_lsb_lp    = 4;
    localparam int size_lsb_lp    = 4 + paddr_width_p;

    localparam logic [3:0] msg_wr_lp    = 4'd1;
    localparam logic [3:0] msg_uc_wr_lp = 4'd3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    typedef logic [paddr_width_p-1:0] addr_t;
    typedef logic [cnt_width_lp:0]    beats_t;

    if ((in_data_width_p % out_data_width_p) != 0 || in_data_width_p <= out_data_width_p) begin : g_bad_width
        $error("bp_lite_to_stream: in_data_width_p must be a larger multiple of out_data_width_p");
    end

    logic [0:0]                                         state_r;
    logic [cnt_width_lp-1:0]                            cnt_r;
    logic [mem_header_width_lp-1:0]                     hdr_r;
    logic [max_beats_lp-1:0][out_data_width_p-1:0]      data_r;
    logic                                               init_r;

    logic [3:0]  msg_type;
    logic [2:0]  msg_size;
    addr_t       base_addr;
    logic        is_wr;
    logic [2:0]  shift_amt;
    logic [8:0]  want_beats;
    beats_t      n_beats;
    logic        last_beat;
    logic [2:0]  blk_lg;
    addr_t       blk_mask;
    addr_t       beat_offset;
    addr_t       beat_addr;

    assign msg_type  = hdr_r[3:0];
    assign msg_size  = hdr_r[size_lsb_lp +: 3];
    assign base_addr = hdr_r[addr_lsb_lp +: paddr_width_p];
    assign is_wr     = (msg_type == msg_wr_lp) || (msg_type == msg_uc_wr_lp);

    // Sub-beat sizes and the no-data direction both collapse to a single beat
    always_comb begin
        shift_amt  = msg_size - 3'(lg_bytes_lp);
        want_beats = 9'd1 << shift_amt;
        n_beats    = beats_t'(1);
        if (!(master_p ^ is_wr) && (msg_size > 3'(lg_bytes_lp))) begin
            n_beats = (want_beats > 9'(max_beats_lp)) ? beats_t'(max_beats_lp)
                                                      : want_beats[cnt_width_lp:0];
        end
    end

    assign last_beat = ({1'b0, cnt_r} == (n_beats - beats_t'(1)));

    // Beat address advances within the size-aligned block and wraps there
    always_comb begin
        blk_lg      = (msg_size > 3'(lg_bytes_lp)) ? msg_size : 3'(lg_bytes_lp);
        blk_mask    = (addr_t'(1) << blk_lg) - addr_t'(1);
        beat_offset = addr_t'(cnt_r) << lg_bytes_lp;
        beat_addr   = (base_addr & ~blk_mask) | ((base_addr + beat_offset) & blk_mask);
    end

    always_comb begin
        mem_header_o = hdr_r;
        mem_header_o[addr_lsb_lp +: paddr_width_p] = beat_addr;
    end

    assign mem_data_o  = data_r[cnt_r];
    assign mem_v_o     = (state_r == SEND);
    assign mem_ready_o = init_r & (state_r == IDLE);
    assign mem_lock_o  = mem_v_o & ~last_beat;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            hdr_r   <= '0;
            data_r  <= '0;
            init_r  <= 1'b0;
        end else begin
            init_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (mem_v_i && mem_ready_o) begin
                        hdr_r   <= mem_i[in_data_width_p +: mem_header_width_lp];
                        data_r  <= mem_i[in_data_width_p-1:0];
                        cnt_r   <= '0;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (mem_ready_and_i) begin
                        if (last_beat) begin
                            cnt_r   <= '0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_lite_to_stream.sv
// tb/tb_bp_lite_to_stream.sv - scoreboard bench for bp_lite_to_stream, command and response variants
module tb_bp_lite_to_stream;

    localparam int PA = 40;
    localparam int PL = 24;
    localparam int IW = 512;
    localparam int OW = 64;
    localparam int HW = 4 + PA + 3 + PL;

    localparam logic [3:0] T_RD = 4'd0, T_WR = 4'd1, T_UC_RD = 4'd2, T_UC_WR = 4'd3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [HW+IW-1:0] mem_i = '0;
    logic          mem_v = 1'b0;
    logic          sel = 1'b1;
    logic          ready_and = 1'b1;

    logic          m_ready, m_v, m_lock, s_ready, s_v, s_lock;
    logic [HW-1:0] m_hdr, s_hdr;
    logic [OW-1:0] m_data, s_data;

    logic          o_ready, o_v, o_lock;
    logic [HW-1:0] o_hdr;
    logic [OW-1:0] o_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [HW-1:0] hdr;
        logic [OW-1:0] data;
        logic          lock;
    } beat_t;
    beat_t sb[$];

    always #5 clk = ~clk;

    bp_lite_to_stream #(.paddr_width_p(PA), .payload_width_p(PL), .in_data_width_p(IW),
                        .out_data_width_p(OW), .master_p(1'b1)) dut_m (
        .clk_i(clk), .reset_n_i(reset_n), .mem_i(mem_i), .mem_v_i(mem_v & sel),
        .mem_ready_o(m_ready), .mem_header_o(m_hdr), .mem_data_o(m_data), .mem_v_o(m_v),
        .mem_ready_and_i(ready_and), .mem_lock_o(m_lock));

    bp_lite_to_stream #(.paddr_width_p(PA), .payload_width_p(PL), .in_data_width_p(IW),
                        .out_data_width_p(OW), .master_p(1'b0)) dut_s (
        .clk_i(clk), .reset_n_i(reset_n), .mem_i(mem_i), .mem_v_i(mem_v & ~sel),
        .mem_ready_o(s_ready), .mem_header_o(s_hdr), .mem_data_o(s_data), .mem_v_o(s_v),
        .mem_ready_and_i(ready_and), .mem_lock_o(s_lock));

    assign o_ready = sel ? m_ready : s_ready;
    assign o_v     = sel ? m_v     : s_v;
    assign o_lock  = sel ? m_lock  : s_lock;
    assign o_hdr   = sel ? m_hdr   : s_hdr;
    assign o_data  = sel ? m_data  : s_data;

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                             input logic [PA-1:0] a, input logic [PL-1:0] pl);
        return {pl, sz, a, t};
    endfunction

    function automatic logic [IW-1:0] mk_data(input logic [7:0] seed);
        logic [IW-1:0] d;
        for (int k = 0; k < IW/OW; k++)
            d[k*OW +: OW] = {seed, 24'(k), 32'hCAFE_0000 + 32'(k * 17)};
        return d;
    endfunction

    task automatic push_expect(input bit master, input logic [3:0] t, input logic [2:0] sz,
                               input logic [PA-1:0] base, input logic [PL-1:0] pl,
                               input logic [IW-1:0] d);
        bit is_wr;
        int n, s;
        logic [PA-1:0] blk, off, a;
        beat_t b;
        is_wr = (t == T_WR) || (t == T_UC_WR);
        if (master ^ is_wr) n = 1;
        else begin
            n = (1 << sz) / (OW/8);
            if (n < 1) n = 1;
            if (n > IW/OW) n = IW/OW;
        end
        s = (sz > 3) ? int'(sz) : 3;
        blk = PA'(1) << s;
        for (int k = 0; k < n; k++) begin
            off = ((base % blk) + PA'(k * (OW/8))) % blk;
            a = base - (base % blk) + off;
            b.hdr  = mk_hdr(t, sz, a, pl);
            b.data = d[k*OW +: OW];
            b.lock = (k != n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic send(input bit to_m, input logic [HW-1:0] hdr, input logic [IW-1:0] d);
        int budget;
        sel = to_m;
        budget = 0;
        @(negedge clk);
        while (o_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            total_cnt++;
            $display("FAIL send_ready_timeout got ready=%b required 1", o_ready);
        end
        mem_i = {hdr, d};
        mem_v = 1'b1;
        @(posedge clk);
        #1;
        mem_v = 1'b0;
        mem_i = ~mem_i;
    endtask

    task automatic collect(input string name, input int stall_beat, input int stall_cycles,
                           input int stop_after);
        int got, stalled, budget;
        bit first;
        beat_t e;
        got = 0; stalled = 0; budget = 0; first = 1'b1;
        while (sb.size() > 0 && got < stop_after && budget < 200) begin
            @(negedge clk);
            budget++;
            ready_and = !(got == stall_beat && stalled < stall_cycles);
            if (first) begin
                total_cnt++;
                if (o_v !== 1'b1) $display("FAIL %s_first_beat_latency got v=%b required 1", name, o_v);
                else pass_cnt++;
                first = 1'b0;
            end
            if (o_v !== 1'b1) begin
                total_cnt++;
                $display("FAIL %s_beat_valid beat %0d got v=%b required 1", name, got, o_v);
                break;
            end
            e = sb[0];
            total_cnt++;
            if (o_hdr !== e.hdr) $display("FAIL %s_hdr beat %0d got %h required %h", name, got, o_hdr, e.hdr);
            else pass_cnt++;
            total_cnt++;
            if (o_data !== e.data) $display("FAIL %s_data beat %0d got %h required %h", name, got, o_data, e.data);
            else pass_cnt++;
            total_cnt++;
            if (o_lock !== e.lock) $display("FAIL %s_lock beat %0d got %b required %b", name, got, o_lock, e.lock);
            else pass_cnt++;
            total_cnt++;
            if (o_ready !== 1'b0) $display("FAIL %s_ready_in_send beat %0d got %b required 0", name, got, o_ready);
            else pass_cnt++;
            if (ready_and) begin
                void'(sb.pop_front());
                got++;
            end else begin
                stalled++;
            end
        end
        if (budget >= 200) begin
            total_cnt++;
            $display("FAIL %s_collect_timeout got %0d beats, %0d still expected", name, got, sb.size());
        end
        ready_and = 1'b1;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        total_cnt++;
        if (o_ready !== 1'b1 || o_v !== 1'b0)
            $display("FAIL %s_idle got ready=%b v=%b required ready=1 v=0", name, o_ready, o_v);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({m_v, m_lock, m_ready, s_v, s_lock, s_ready} !== 6'b0)
            $display("FAIL reset_outputs got %b required 000000", {m_v, m_lock, m_ready, s_v, s_lock, s_ready});
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (m_ready !== 1'b1 || s_ready !== 1'b1)
            $display("FAIL reset_release_ready got m=%b s=%b required 1 1", m_ready, s_ready);
        else pass_cnt++;
    endtask

    task automatic test_uc_wr_burst();
        logic [IW-1:0] d = mk_data(8'h11);
        push_expect(1'b1, T_UC_WR, 3'd6, 40'h1000, 24'h00AB01, d);
        send(1'b1, mk_hdr(T_UC_WR, 3'd6, 40'h1000, 24'h00AB01), d);
        collect("uc_wr_burst", -1, 0, 100);
        check_idle("uc_wr_burst");
    endtask

    task automatic test_uc_rd_single();
        logic [IW-1:0] d = mk_data(8'h22);
        push_expect(1'b1, T_UC_RD, 3'd6, 40'h2000, 24'h00AB02, d);
        send(1'b1, mk_hdr(T_UC_RD, 3'd6, 40'h2000, 24'h00AB02), d);
        collect("uc_rd_single", -1, 0, 100);
        check_idle("uc_rd_single");
    endtask

    task automatic test_rd_resp_wrap();
        logic [IW-1:0] d = mk_data(8'h33);
        push_expect(1'b0, T_RD, 3'd6, 40'h1020, 24'h00AB03, d);
        send(1'b0, mk_hdr(T_RD, 3'd6, 40'h1020, 24'h00AB03), d);
        collect("rd_resp_wrap", -1, 0, 100);
        check_idle("rd_resp_wrap");
    endtask

    task automatic test_small_write();
        logic [IW-1:0] d = mk_data(8'h44);
        push_expect(1'b1, T_WR, 3'd2, 40'h3004, 24'h00AB04, d);
        send(1'b1, mk_hdr(T_WR, 3'd2, 40'h3004, 24'h00AB04), d);
        collect("small_write", -1, 0, 100);
        check_idle("small_write");
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] d = mk_data(8'h55);
        push_expect(1'b1, T_WR, 3'd6, 40'h5000, 24'h00AB05, d);
        send(1'b1, mk_hdr(T_WR, 3'd6, 40'h5000, 24'h00AB05), d);
        collect("backpressure", 2, 3, 100);
        check_idle("backpressure");
    endtask

    task automatic test_reset_mid_burst();
        logic [IW-1:0] d = mk_data(8'h66);
        logic [IW-1:0] d2 = mk_data(8'h77);
        push_expect(1'b1, T_WR, 3'd6, 40'h6000, 24'h00AB06, d);
        send(1'b1, mk_hdr(T_WR, 3'd6, 40'h6000, 24'h00AB06), d);
        collect("pre_reset", -1, 0, 4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (o_v !== 1'b0 || o_lock !== 1'b0 || o_ready !== 1'b0)
            $display("FAIL reset_mid_burst_async got v=%b lock=%b ready=%b required 0 0 0", o_v, o_lock, o_ready);
        else pass_cnt++;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        check_idle("reset_mid_burst_release");
        push_expect(1'b1, T_WR, 3'd6, 40'h7000, 24'h00AB07, d2);
        send(1'b1, mk_hdr(T_WR, 3'd6, 40'h7000, 24'h00AB07), d2);
        collect("post_reset", -1, 0, 100);
        check_idle("post_reset");
    endtask

    initial begin
        test_reset();
        test_uc_wr_burst();
        test_uc_rd_single();
        test_rd_resp_wrap();
        test_small_write();
        test_backpressure();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
